mem_arbiter: RTL

// - Shares one memory bus between the I-cache refill port and the data-memory port of the datapath.
// - Single outstanding transaction. Request fields are registered at grant; the bus is held until ack.
// - The read data or an error is returned to the winning requester as a one-cycle pulse.
// - Sits between datapath/core top and the system memory or interconnect.

---
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of requester and memory-bus signals around mem_arbiter.
// Ports (as signals of the interface):
//   I-cache : i_ic_req, i_ic_addr -> o_ic_data, o_ic_ready, o_ic_err
//   Data    : i_dm_req, i_dm_we, i_dm_be, i_dm_addr, i_dm_wdata
//             -> o_dm_rdata, o_dm_ready, o_dm_err
//   Memory  : o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata <- i_mem_rdata, i_mem_ack
// Modports: master = arbiter view (it masters the memory bus),
//           slave  = environment view (requesters plus memory).
interface mem_arbiter_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            i_ic_req;
  logic [XLEN-1:0] i_ic_addr;
  logic [XLEN-1:0] o_ic_data;
  logic            o_ic_ready;
  logic            o_ic_err;

  logic            i_dm_req;
  logic            i_dm_we;
  logic [3:0]      i_dm_be;
  logic [XLEN-1:0] i_dm_addr;
  logic [XLEN-1:0] i_dm_wdata;
  logic [XLEN-1:0] o_dm_rdata;
  logic            o_dm_ready;
  logic            o_dm_err;

  logic            o_mem_req;
  logic            o_mem_we;
  logic [3:0]      o_mem_be;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wdata;
  logic [XLEN-1:0] i_mem_rdata;
  logic            i_mem_ack;

  modport master (
    input  i_ic_req, i_ic_addr,
    output o_ic_data, o_ic_ready, o_ic_err,
    input  i_dm_req, i_dm_we, i_dm_be, i_dm_addr, i_dm_wdata,
    output o_dm_rdata, o_dm_ready, o_dm_err,
    output o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata, i_mem_ack
  );

  modport slave (
    output i_ic_req, i_ic_addr,
    input  o_ic_data, o_ic_ready, o_ic_err,
    output i_dm_req, i_dm_we, i_dm_be, i_dm_addr, i_dm_wdata,
    input  o_dm_rdata, o_dm_ready, o_dm_err,
    input  o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
    output i_mem_rdata, i_mem_ack
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between the I-cache refill port and the data port.
// Single outstanding transaction; request fields are registered at grant and held until
// ack or timeout abort. Completion (ready) or abort (err) is a one-cycle pulse.
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - asynchronous active-low reset
//   bus    - mem_arbiter_if.master (requester ports and memory bus)
// Parameters:
//   XLEN    - address/data width
//   TIMEOUT - BUSY cycles without ack before abort; 0 disables the abort
// Configuration macro:
//   ARB_ROUND_ROBIN_EN - if defined, ties go to the port not granted last;
//                        otherwise the data port always wins ties.
module mem_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mem_arbiter_if.master bus
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {StIdle, StBusyIc, StBusyDm, StResp} state_e;

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic          grant_dm;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_dm_q;

  always_comb begin
    grant_dm = bus.i_dm_req;
    if (bus.i_ic_req && bus.i_dm_req) begin
      grant_dm = ~last_grant_dm_q;
    end
  end
`else
  // Data port wins any tie.
  always_comb begin
    grant_dm = bus.i_dm_req;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q         <= StIdle;
      timer_q         <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_dm_q <= 1'b0;
`endif
      bus.o_ic_data   <= '0;
      bus.o_ic_ready  <= 1'b0;
      bus.o_ic_err    <= 1'b0;
      bus.o_dm_rdata  <= '0;
      bus.o_dm_ready  <= 1'b0;
      bus.o_dm_err    <= 1'b0;
      bus.o_mem_req   <= 1'b0;
      bus.o_mem_we    <= 1'b0;
      bus.o_mem_be    <= '0;
      bus.o_mem_addr  <= '0;
      bus.o_mem_wdata <= '0;
    end else begin
      // Completion/abort strobes are single-cycle by default.
      bus.o_ic_ready <= 1'b0;
      bus.o_ic_err   <= 1'b0;
      bus.o_dm_ready <= 1'b0;
      bus.o_dm_err   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (bus.i_ic_req || bus.i_dm_req) begin
            bus.o_mem_req <= 1'b1;
            timer_q       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_dm_q <= grant_dm;
`endif
            if (grant_dm) begin
              bus.o_mem_we    <= bus.i_dm_we;
              bus.o_mem_be    <= bus.i_dm_be;
              bus.o_mem_addr  <= bus.i_dm_addr;
              bus.o_mem_wdata <= bus.i_dm_wdata;
              state_q         <= StBusyDm;
            end else begin
              bus.o_mem_we    <= 1'b0;
              bus.o_mem_be    <= 4'hF;
              bus.o_mem_addr  <= bus.i_ic_addr;
              bus.o_mem_wdata <= '0;
              state_q         <= StBusyIc;
            end
          end
        end

        StBusyIc, StBusyDm: begin
          if (bus.i_mem_ack) begin
            // Ack beats a coincident timeout.
            bus.o_mem_req <= 1'b0;
            state_q       <= StResp;
            if (state_q == StBusyIc) begin
              bus.o_ic_data  <= bus.i_mem_rdata;
              bus.o_ic_ready <= 1'b1;
            end else begin
              bus.o_dm_rdata <= bus.o_mem_we ? '0 : bus.i_mem_rdata;
              bus.o_dm_ready <= 1'b1;
            end
          end else if ((TIMEOUT != 0) && (timer_q == TMAX)) begin
            bus.o_mem_req <= 1'b0;
            state_q       <= StResp;
            if (state_q == StBusyIc) begin
              bus.o_ic_err <= 1'b1;
            end else begin
              bus.o_dm_err <= 1'b1;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        StResp: begin
          // Requester retires at this edge; its req is not sampled here.
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
